// File: rtl/vend_change.sv
//-----------------------------------------------------------------------------
// vend_change
//
// Vending-machine purchase and change controller. On a purchase request the
// four-digit BCD balance and the product id are latched, the price is checked,
// the product is dispensed through a valid/ready handshake and the change is
// paid out greedily, one coin per handshake, largest denomination first. A
// remainder below the smallest coin (5) is reported on residue, and a one-cycle
// balance_clear pulse tells the upstream money accumulator to zero itself.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   clear          synchronous active-high reset, overrides everything
//   money_0..3     BCD balance digits, units..thousands
//   buy            purchase request, only honoured while idle
//   select         product id (00=15, 01=20, 10=35, 11=50)
//   vend_valid     product dispense request
//   vend_id        product being dispensed (latched select)
//   vend_ready     dispenser accepts the product
//   coin_valid     a change coin is offered
//   coin_code      denomination: 1=5 2=10 3=20 4=50 5=100 6=200 7=500
//   coin_ready     coin hopper accepts the coin
//   no_fund        one-cycle pulse, balance was below the price
//   balance_clear  one-cycle pulse, purchase finished, clear the balance
//   busy           a purchase is in progress
//   residue        undispensable remainder 0..4 of the last purchase
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module vend_change (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] money_0,
    input  logic [3:0] money_1,
    input  logic [3:0] money_2,
    input  logic [3:0] money_3,
    input  logic       buy,
    input  logic [1:0] select,
    output logic       vend_valid,
    output logic [1:0] vend_id,
    input  logic       vend_ready,
    output logic       coin_valid,
    output logic [2:0] coin_code,
    input  logic       coin_ready,
    output logic       no_fund,
    output logic       balance_clear,
    output logic       busy,
    output logic [2:0] residue
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_VEND,
        S_CHANGE,
        S_DONE
    } state_t;

    //-------------------------------------------------------------------------
    // BCD helpers
    //-------------------------------------------------------------------------

    // Product price as a 4-digit BCD value.
    function automatic logic [15:0] price_of(input logic [1:0] id);
        logic [15:0] p;
        case (id)
            2'b00:   p = 16'h0015;
            2'b01:   p = 16'h0020;
            2'b10:   p = 16'h0035;
            default: p = 16'h0050;
        endcase
        return p;
    endfunction

    // Digit-serial BCD subtraction a - b with borrow ripple. Callers
    // guarantee a >= b, so the final borrow is always zero.
    function automatic logic [15:0] bcd_sub(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [15:0] r;
        logic        borrow;
        logic [4:0]  d;
        r      = '0;
        borrow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
            if (d[4]) begin
                // Negative digit: wrap into 0..9 by adding ten (mod 16).
                r[4*i +: 4] = d[3:0] + 4'd10;
                borrow      = 1'b1;
            end else begin
                r[4*i +: 4] = d[3:0];
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    // Largest denomination not exceeding the remaining change; 0 when the
    // change is below the smallest coin. Valid BCD compares correctly as a
    // plain binary number, so no digit-wise comparison is needed.
    function automatic logic [2:0] coin_pick(input logic [15:0] amount);
        logic [2:0] c;
        if      (amount >= 16'h0500) c = 3'd7;
        else if (amount >= 16'h0200) c = 3'd6;
        else if (amount >= 16'h0100) c = 3'd5;
        else if (amount >= 16'h0050) c = 3'd4;
        else if (amount >= 16'h0020) c = 3'd3;
        else if (amount >= 16'h0010) c = 3'd2;
        else if (amount >= 16'h0005) c = 3'd1;
        else                         c = 3'd0;
        return c;
    endfunction

    // BCD value of a coin code.
    function automatic logic [15:0] coin_value(input logic [2:0] code);
        logic [15:0] v;
        case (code)
            3'd1:    v = 16'h0005;
            3'd2:    v = 16'h0010;
            3'd3:    v = 16'h0020;
            3'd4:    v = 16'h0050;
            3'd5:    v = 16'h0100;
            3'd6:    v = 16'h0200;
            3'd7:    v = 16'h0500;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    //-------------------------------------------------------------------------
    // State and datapath registers
    //-------------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic [15:0] balance_q;   // balance latched at purchase start
    logic [1:0]  sel_q;       // product latched at purchase start
    logic [15:0] change_q;    // change still owed, BCD
    logic [2:0]  residue_q;
    logic        no_fund_q;

    logic [15:0] price;
    logic        short_fund;
    logic [2:0]  pick_code;
    logic        coin_avail;
    logic        buy_take;
    logic        coin_fire;

    assign price      = price_of(sel_q);
    assign short_fund = (balance_q < price);
    assign pick_code  = coin_pick(change_q);
    assign coin_avail = (pick_code != 3'd0);
    assign buy_take   = (state_q == S_IDLE) && buy;
    assign coin_fire  = coin_valid && coin_ready;

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its sources, independent of block ordering.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    //-------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d       = state_q;
        vend_valid    = 1'b0;
        coin_valid    = 1'b0;
        balance_clear = 1'b0;
        busy          = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (buy) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (short_fund) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_VEND;
                end
            end

            S_VEND: begin
                vend_valid = 1'b1;
                if (vend_ready) begin
                    state_d = S_CHANGE;
                end
            end

            S_CHANGE: begin
                // Stay here while coins remain; the change register is
                // reduced on each accepted coin and re-evaluated next cycle.
                if (coin_avail) begin
                    coin_valid = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                balance_clear = 1'b1;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Datapath
    //-------------------------------------------------------------------------
    // NOTE: every register here is a handful of flops with a defined reset
    // value; there is no storage array, so clearing all of it costs nothing.
    always_ff @(posedge clk) begin
        if (clear) begin
            balance_q <= '0;
            sel_q     <= '0;
            change_q  <= '0;
            residue_q <= '0;
            no_fund_q <= 1'b0;
        end else begin
            // Inputs are captured once; later changes of money/select are
            // invisible to the running purchase.
            if (buy_take) begin
                balance_q <= {money_3, money_2, money_1, money_0};
                sel_q     <= select;
                residue_q <= '0;
            end

            // Registered so the pulse lands in the cycle after CHECK.
            no_fund_q <= (state_q == S_CHECK) && short_fund;

            if ((state_q == S_CHECK) && !short_fund) begin
                change_q <= bcd_sub(balance_q, price);
            end else if (coin_fire) begin
                change_q <= bcd_sub(change_q, coin_value(pick_code));
            end

            // Remaining change is below 5, so only the units digit is
            // nonzero and it fits in three bits.
            if ((state_q == S_CHANGE) && !coin_avail) begin
                residue_q <= change_q[2:0];
            end
        end
    end

    //-------------------------------------------------------------------------
    // Registered / gated outputs
    //-------------------------------------------------------------------------
    assign vend_id   = sel_q;
    assign coin_code = coin_valid ? pick_code : 3'd0;
    assign no_fund   = no_fund_q;
    assign residue   = residue_q;

endmodule

// File: tb/tb_vend_change.sv
//-----------------------------------------------------------------------------
// tb_vend_change
//
// Scoreboard bench for vend_change. Each accepted purchase pushes the events
// the controller must produce (dispense, coins in order, no-fund or final
// clear with residue) into a queue; an independent monitor pops and compares
// them as the DUT presents them. Expected events come from integer arithmetic
// and a greedy change loop over the coin list.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vend_change;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] money_0, money_1, money_2, money_3;
    logic       buy;
    logic [1:0] select;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       vend_ready;
    logic       coin_valid;
    logic [2:0] coin_code;
    logic       coin_ready;
    logic       no_fund;
    logic       balance_clear;
    logic       busy;
    logic [2:0] residue;

    vend_change dut (
        .clk           (clk),
        .clear         (clear),
        .money_0       (money_0),
        .money_1       (money_1),
        .money_2       (money_2),
        .money_3       (money_3),
        .buy           (buy),
        .select        (select),
        .vend_valid    (vend_valid),
        .vend_id       (vend_id),
        .vend_ready    (vend_ready),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .coin_ready    (coin_ready),
        .no_fund       (no_fund),
        .balance_clear (balance_clear),
        .busy          (busy),
        .residue       (residue)
    );

    initial forever #5 clk = ~clk;

    typedef enum int {EV_VEND, EV_COIN, EV_NOFUND, EV_CLEAR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
        int       cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   coins_seen = 0;
    int   ready_pct  = 100;
    logic hold_low   = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    //-------------------------------------------------------------------------
    // Reference model
    //-------------------------------------------------------------------------
    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int tb_price(input logic [1:0] id);
        case (id)
            2'd0:    return 15;
            2'd1:    return 20;
            2'd2:    return 35;
            default: return 50;
        endcase
    endfunction

    function automatic int denom(input int code);
        case (code)
            1:       return 5;
            2:       return 10;
            3:       return 20;
            4:       return 50;
            5:       return 100;
            6:       return 200;
            default: return 500;
        endcase
    endfunction

    task automatic push_ev(input ev_kind_t kind, input int val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // acc = cycle count right after the accepting edge (the CHECK cycle).
    task automatic push_expect(input logic [15:0] bal, input logic [1:0] sel, input int acc);
        int b;
        int p;
        int ch;
        b = bcd2int(bal);
        p = tb_price(sel);
        if (b < p) begin
            push_ev(EV_NOFUND, 0, acc + 1);
        end else begin
            push_ev(EV_VEND, int'(sel), 0);
            ch = b - p;
            for (int c = 7; c >= 1; c--) begin
                while (ch >= denom(c)) begin
                    push_ev(EV_COIN, c, 0);
                    ch -= denom(c);
                end
            end
            push_ev(EV_CLEAR, ch, 0);
        end
    endtask

    //-------------------------------------------------------------------------
    // Monitor: samples on the falling edge, between driving and the next
    // active edge. A handshake seen here completes at the next rising edge
    // unless clear is asserted, which overrides it.
    //-------------------------------------------------------------------------
    task automatic got(input ev_kind_t kind, input int val, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected: got %0d expected no event (cycle %0d)", name, val, cyc);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_kind"}, int'(kind), int'(e.kind));
        if (kind == e.kind) begin
            if (kind == EV_NOFUND) check("no_fund_cycle", cyc, e.cyc);
            else                   check(name, val, e.val);
        end
    endtask

    initial begin
        logic       p_cv  = 1'b0;
        logic       p_cr  = 1'b0;
        logic [2:0] p_cc  = '0;
        logic       p_vv  = 1'b0;
        logic       p_vr  = 1'b0;
        logic [1:0] p_id  = '0;
        logic       p_clr = 1'b1;
        forever begin
            @(negedge clk);
            if (!p_clr && p_cv && !p_cr) begin
                check("coin_valid_hold", int'(coin_valid), 1);
                check("coin_code_hold", int'(coin_code), int'(p_cc));
            end
            if (!p_clr && p_vv && !p_vr) begin
                check("vend_valid_hold", int'(vend_valid), 1);
                check("vend_id_hold", int'(vend_id), int'(p_id));
            end
            if (!clear) begin
                if (vend_valid && vend_ready) got(EV_VEND, int'(vend_id), "vend_id");
                if (coin_valid && coin_ready) begin
                    got(EV_COIN, int'(coin_code), "coin_code");
                    coins_seen++;
                end
                if (no_fund) got(EV_NOFUND, 0, "no_fund");
                if (balance_clear) got(EV_CLEAR, int'(residue), "residue");
            end
            p_cv  = coin_valid;
            p_cr  = coin_ready;
            p_cc  = coin_code;
            p_vv  = vend_valid;
            p_vr  = vend_ready;
            p_id  = vend_id;
            p_clr = clear;
        end
    end

    // Ready driver, a little after the main stimulus so it sees hold_low.
    initial begin
        vend_ready = 1'b0;
        coin_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            vend_ready = ($urandom_range(99) < ready_pct);
            coin_ready = hold_low ? 1'b0 : ($urandom_range(99) < ready_pct);
        end
    end

    //-------------------------------------------------------------------------
    // Stimulus helpers (all called at rising edge + 1)
    //-------------------------------------------------------------------------
    task automatic scramble_inputs();
        {money_3, money_2, money_1, money_0} = 16'($urandom);
        select = 2'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vend_valid"}, int'(vend_valid), 0);
        check({tag, "_vend_id"}, int'(vend_id), 0);
        check({tag, "_coin_valid"}, int'(coin_valid), 0);
        check({tag, "_coin_code"}, int'(coin_code), 0);
        check({tag, "_no_fund"}, int'(no_fund), 0);
        check({tag, "_balance_clear"}, int'(balance_clear), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_residue"}, int'(residue), 0);
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        buy      = 1'b0;
        hold_low = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic do_txn(input logic [15:0] bal, input logic [1:0] sel,
                          input int inject, input bit hold, input bit abort);
        int n;
        int coins0;
        int held;
        bit finished;
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_before_buy", int'(busy), 0);
        {money_3, money_2, money_1, money_0} = bal;
        select   = sel;
        buy      = 1'b1;
        hold_low = hold;
        @(posedge clk);
        #1;
        buy = 1'b0;
        scramble_inputs();
        check("busy_after_buy", int'(busy), 1);
        push_expect(bal, sel, cyc);
        coins0   = coins_seen;
        held     = 0;
        finished = 1'b0;
        for (n = 0; n < 2000; n++) begin
            if (exp_q.size() == 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            if (abort && coins_seen != coins0) begin
                do_clear();
                check_idle("abort");
                finished = 1'b1;
                break;
            end
            if (hold_low && coin_valid) begin
                held++;
                if (held > 3) hold_low = 1'b0;
            end
            // Extra buys only while VEND/CHANGE is certain to persist past
            // the next edge; they must be ignored.
            if ((vend_valid || coin_valid) && $urandom_range(99) < inject) begin
                buy = 1'b1;
                scramble_inputs();
            end
            @(posedge clk);
            #1;
            buy = 1'b0;
        end
        hold_low = 1'b0;
        check("txn_complete", int'(finished), 1);
        if (!finished) do_clear();
    endtask

    function automatic logic [15:0] rand_bal();
        logic [15:0] b;
        b[15:12] = ($urandom_range(3) == 0) ? 4'($urandom_range(9)) : 4'd0;
        b[11:8]  = ($urandom_range(1) == 0) ? 4'($urandom_range(9)) : 4'd0;
        b[7:4]   = 4'($urandom_range(9));
        b[3:0]   = 4'($urandom_range(9));
        return b;
    endfunction

    //-------------------------------------------------------------------------
    // Main sequence
    //-------------------------------------------------------------------------
    initial begin
        clear = 1'b1;
        buy   = 1'b1;     // clear must win over a simultaneous buy
        {money_3, money_2, money_1, money_0} = 16'h0999;
        select = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;
        buy   = 1'b0;
        check_idle("reset");

        ready_pct = 100;
        do_txn(16'h0020, 2'd0, 0, 1'b0, 1'b0);   // one 5 coin, residue 0
        do_txn(16'h0010, 2'd1, 0, 1'b0, 1'b0);   // no_fund
        do_txn(16'h0385, 2'd3, 0, 1'b0, 1'b0);   // 200,100,20,10,5
        do_txn(16'h0053, 2'd3, 0, 1'b1, 1'b0);   // no coin, residue 3
        do_txn(16'h0070, 2'd3, 0, 1'b1, 1'b0);   // 20 held three cycles
        do_txn(16'h0385, 2'd3, 0, 1'b0, 1'b1);   // clear after first coin
        do_txn(16'h0020, 2'd0, 0, 1'b0, 1'b0);   // normal after abort
        do_txn(16'h0035, 2'd2, 80, 1'b0, 1'b0);  // exact, buys while busy
        do_txn(16'h9999, 2'd0, 20, 1'b0, 1'b0);  // largest change
        do_txn(16'h0014, 2'd0, 0, 1'b0, 1'b0);   // one below price
        do_txn(16'h0109, 2'd3, 0, 1'b0, 1'b0);   // borrow across digits

        for (int t = 0; t < 40; t++) begin
            ready_pct = $urandom_range(100, 25);
            do_txn(rand_bal(), 2'($urandom), 30, ($urandom_range(4) == 0), 1'b0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
